// File: rtl/vote_logger_if.sv
// Bundles the voter-facing signals of vote_logger: mode select, debounced
// vote pulses in, and the display/status outputs back to the panel.
interface vote_logger_if #(
    parameter int COUNT_WIDTH = 8
);
    logic                   mode;
    logic [3:0]             valid_vote;
    logic [COUNT_WIDTH-1:0] leds;
    logic                   ack;
    logic                   reject;
    logic                   busy;

    // Panel side: drives mode and votes, observes the display
    modport master (
        output mode,
        output valid_vote,
        input  leds,
        input  ack,
        input  reject,
        input  busy
    );

    // Logger side
    modport slave (
        input  mode,
        input  valid_vote,
        output leds,
        output ack,
        output reject,
        output busy
    );
endinterface

// File: rtl/vote_logger.sv
// Four-candidate vote logger. In voting mode a single vote is counted
// (saturating tally), acknowledged and followed by a lockout window in which
// further votes are ignored; simultaneous votes are rejected. In result mode
// the display shows the tally of a candidate chosen with the vote buttons.
module vote_logger #(
    parameter int COUNT_WIDTH    = 8,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic          clock,
    input  logic          reset,
    vote_logger_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKOUT = 2'd1,
        RESULT  = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_LOAD = 8'(LOCKOUT_CYCLES);

    state_t                 state_reg, state_next;
    logic [7:0]             lock_reg, lock_next;
    logic [1:0]             sel_reg, sel_next;
    logic [COUNT_WIDTH-1:0] leds_reg, leds_next;
    logic                   ack_reg, ack_next;
    logic                   reject_reg, reject_next;

    logic [3:0]             inc;
    logic [COUNT_WIDTH-1:0] tally [4];
    logic                   vote_one_hot;
    logic                   vote_multi;
    logic [1:0]             vote_index;

    // Classify the incoming pulses: exactly one button, or a collision
    assign vote_one_hot = (bus.valid_vote != 4'd0) &&
                          ((bus.valid_vote & (bus.valid_vote - 4'd1)) == 4'd0);
    assign vote_multi   = (bus.valid_vote != 4'd0) && !vote_one_hot;

    // Candidate index of a one-hot vote (only used when vote_one_hot is set)
    always_comb begin
        vote_index = 2'd0;
        case (bus.valid_vote)
            4'b0010: vote_index = 2'd1;
            4'b0100: vote_index = 2'd2;
            4'b1000: vote_index = 2'd3;
            default: vote_index = 2'd0;
        endcase
    end

    // One saturating tally per candidate, bumped only on an accepted vote
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_tally
            logic [COUNT_WIDTH-1:0] count_reg;

            // Increment unless already at full scale
            always_ff @(posedge clock) begin
                if (reset) begin
                    count_reg <= '0;
                end else if (inc[gi] && (count_reg != {COUNT_WIDTH{1'b1}})) begin
                    count_reg <= count_reg + COUNT_WIDTH'(1);
                end
            end

            assign tally[gi] = count_reg;
        end
    endgenerate

    // Next-state and registered-output decisions
    always_comb begin
        state_next  = state_reg;
        lock_next   = lock_reg;
        sel_next    = sel_reg;
        ack_next    = 1'b0;
        reject_next = 1'b0;
        leds_next   = '0;
        inc         = 4'd0;

        case (state_reg)
            IDLE: begin
                // Mode wins over any vote arriving in the same cycle
                if (bus.mode) begin
                    state_next = RESULT;
                end else if (vote_one_hot) begin
                    inc        = bus.valid_vote;
                    ack_next   = 1'b1;
                    lock_next  = LOCK_LOAD;
                    state_next = LOCKOUT;
                end else if (vote_multi) begin
                    reject_next = 1'b1;
                end
            end
            LOCKOUT: begin
                // Counter was loaded with the window length; leave on the
                // edge where it hits zero so the window is exactly that long
                lock_next = lock_reg - 8'd1;
                if (lock_reg <= 8'd1) begin
                    state_next = IDLE;
                end
            end
            RESULT: begin
                if (vote_one_hot) begin
                    sel_next = vote_index;
                end
                if (!bus.mode) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Display follows the state being entered; result view lags the
        // selector by one cycle because it samples the current selector
        case (state_next)
            LOCKOUT: leds_next = (state_reg == IDLE) ? COUNT_WIDTH'(bus.valid_vote) : leds_reg;
            RESULT:  leds_next = tally[sel_reg];
            default: leds_next = '0;
        endcase
    end

    // State and output registers; reset drops any pending pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            lock_reg   <= 8'd0;
            sel_reg    <= 2'd0;
            leds_reg   <= '0;
            ack_reg    <= 1'b0;
            reject_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            lock_reg   <= lock_next;
            sel_reg    <= sel_next;
            leds_reg   <= leds_next;
            ack_reg    <= ack_next;
            reject_reg <= reject_next;
        end
    end

    assign bus.leds   = leds_reg;
    assign bus.ack    = ack_reg;
    assign bus.reject = reject_reg;
    assign bus.busy   = (state_reg == LOCKOUT);
endmodule

// File: tb/tb_vote_logger.sv
// Scoreboard bench for vote_logger: directed scenarios plus random traffic,
// expected outputs come from a behavioural model of the voting rules.
module tb_vote_logger;
    localparam int CW   = 8;
    localparam int LOCK = 16;
    localparam int TMAX = (1 << CW) - 1;

    typedef struct {
        logic [CW-1:0] leds;
        logic          ack;
        logic          rej;
        logic          busy;
    } exp_t;

    logic clock;
    logic reset;

    vote_logger_if #(.COUNT_WIDTH(CW)) bus ();

    vote_logger #(
        .COUNT_WIDTH   (CW),
        .LOCKOUT_CYCLES(LOCK)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference model: phase 0 = idle, 1 = lockout, 2 = result
    int m_tally[4];
    int m_sel;
    int m_phase;
    int m_rem;
    int m_shown;

    task automatic cycle(input bit r, input bit m, input logic [3:0] v);
        exp_t e;
        int   pc;
        int   prev_sel;
        int   idx;
        reset          = r;
        bus.mode       = m;
        bus.valid_vote = v;
        pc       = $countones(v);
        prev_sel = m_sel;
        idx      = 0;
        for (int i = 0; i < 4; i++) if (v[i]) idx = i;
        e.ack = 1'b0;
        e.rej = 1'b0;
        if (r) begin
            for (int i = 0; i < 4; i++) m_tally[i] = 0;
            m_sel   = 0;
            m_phase = 0;
            m_rem   = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (m) begin
                        m_phase = 2;
                    end else if (pc == 1) begin
                        if (m_tally[idx] < TMAX) m_tally[idx]++;
                        e.ack   = 1'b1;
                        m_shown = int'(v);
                        m_rem   = LOCK;
                        m_phase = 1;
                    end else if (pc >= 2) begin
                        e.rej = 1'b1;
                    end
                end
                1: begin
                    m_rem--;
                    if (m_rem == 0) m_phase = 0;
                end
                default: begin
                    if (pc == 1) m_sel = idx;
                    if (!m) m_phase = 0;
                end
            endcase
        end
        case (m_phase)
            1:       e.leds = CW'(m_shown);
            2:       e.leds = CW'(m_tally[prev_sel]);
            default: e.leds = '0;
        endcase
        e.busy = (m_phase == 1);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0);
    endtask

    task automatic vote(input logic [3:0] v);
        cycle(1'b0, 1'b0, v);
        idle(LOCK);
    endtask

    // Monitor: compare every registered output against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (bus.leds !== e.leds) begin
                    n_bad++;
                    $display("FAIL leds cycle %0d: got %0h expected %0h", cyc, bus.leds, e.leds);
                end
                n_cmp++;
                if (bus.ack !== e.ack) begin
                    n_bad++;
                    $display("FAIL ack cycle %0d: got %0b expected %0b", cyc, bus.ack, e.ack);
                end
                n_cmp++;
                if (bus.reject !== e.rej) begin
                    n_bad++;
                    $display("FAIL reject cycle %0d: got %0b expected %0b", cyc, bus.reject, e.rej);
                end
                n_cmp++;
                if (bus.busy !== e.busy) begin
                    n_bad++;
                    $display("FAIL busy cycle %0d: got %0b expected %0b", cyc, bus.busy, e.busy);
                end
                if (e.ack)
                    $display("cycle %0d: vote accepted, leds=%0h", cyc, bus.leds);
                else if (e.rej)
                    $display("cycle %0d: simultaneous vote rejected", cyc);
            end
        end
    end

    initial begin
        bit mode_level;
        logic [3:0] v;
        reset          = 1'b1;
        bus.mode       = 1'b0;
        bus.valid_vote = 4'd0;

        // Reset state
        cycle(1'b1, 1'b0, 4'd0);
        cycle(1'b1, 1'b0, 4'd0);

        // Single vote for candidate 2, full lockout, back to idle
        vote(4'b0010);
        idle(2);

        // Simultaneous votes rejected
        cycle(1'b0, 1'b0, 4'b0101);
        idle(2);

        // Votes during lockout ignored, vote right after lockout counted
        cycle(1'b1, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 4'b0001);
        idle(2);
        cycle(1'b0, 1'b0, 4'b0001);
        idle(11);
        cycle(1'b0, 1'b0, 4'b0001);
        idle(1);
        vote(4'b0001);

        // Result display with tallies {3,0,1,2}
        cycle(1'b1, 1'b0, 4'd0);
        vote(4'b0001); vote(4'b0001); vote(4'b0001);
        vote(4'b0100);
        vote(4'b1000); vote(4'b1000);
        cycle(1'b0, 1'b1, 4'd0);
        cycle(1'b0, 1'b1, 4'b0100);
        cycle(1'b0, 1'b1, 4'd0);
        cycle(1'b0, 1'b1, 4'd0);
        cycle(1'b0, 1'b1, 4'b1000);
        cycle(1'b0, 1'b1, 4'd0);
        cycle(1'b0, 1'b1, 4'b0011);
        cycle(1'b0, 1'b1, 4'd0);
        cycle(1'b0, 1'b0, 4'd0);
        idle(2);
        // Mode priority over a same-cycle vote
        cycle(1'b0, 1'b1, 4'b0001);
        cycle(1'b0, 1'b1, 4'b0001);
        cycle(1'b0, 1'b1, 4'd0);
        cycle(1'b0, 1'b0, 4'd0);

        // Reset during lockout, then immediate new vote
        cycle(1'b0, 1'b0, 4'b0010);
        idle(4);
        cycle(1'b1, 1'b0, 4'b0010);
        vote(4'b0001);

        // Saturation: 257 votes for candidate 4
        cycle(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 257; i++) vote(4'b1000);
        cycle(1'b0, 1'b1, 4'b1000);
        cycle(1'b0, 1'b1, 4'd0);
        cycle(1'b0, 1'b1, 4'd0);
        cycle(1'b0, 1'b0, 4'd0);

        // Random traffic
        cycle(1'b1, 1'b0, 4'd0);
        mode_level = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) mode_level = ~mode_level;
            v = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            cycle(($urandom_range(0, 299) == 0), mode_level, v);
        end
        idle(2);

        // Every expectation must have been consumed
        @(negedge clock);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vote_logger.md
VOTE_LOGGER -- requirements
Module: vote_logger

Interface
REQ-001 Parameter COUNT_WIDTH, default 8, width of each per-candidate tally and of the leds output.
REQ-002 Parameter LOCKOUT_CYCLES, default 16, number of cycles votes are ignored after an accepted vote; legal range 1..255.
REQ-003 Port clock  input  1  system clock; all state SHALL update on its rising edge only.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port mode  input  1  0 = voting mode, 1 = result-display mode; level-sensitive.
REQ-006 Port valid_vote  input  4  one bit per candidate (bit 0 = candidate 1); each bit is a single-cycle pulse from a per-button debouncer.
REQ-007 Port leds  output  COUNT_WIDTH  display: accepted-candidate indication or the selected tally.
REQ-008 Port ack  output  1  single-cycle pulse, one per accepted vote.
REQ-009 Port reject  output  1  single-cycle pulse, one per rejected simultaneous vote.
REQ-010 Port busy  output  1  high while in LOCKOUT.

Function
REQ-011 The block SHALL hold four COUNT_WIDTH-bit tallies, one per candidate, plus a 2-bit display selector and a lockout down-counter.
REQ-012 The FSM SHALL have exactly the states IDLE, LOCKOUT and RESULT.
REQ-013 IDLE with mode=0: if exactly one valid_vote bit is high, the block SHALL increment that tally at the next edge, pulse ack for that one cycle, load the lockout counter with LOCKOUT_CYCLES and enter LOCKOUT.
REQ-014 IDLE with mode=0 and two or more valid_vote bits high in the same cycle: the block SHALL leave all tallies unchanged, pulse reject for one cycle at the next edge and remain in IDLE.
REQ-015 IDLE with mode=0 and valid_vote=0: the block SHALL hold state, with ack=0 and reject=0.
REQ-016 IDLE with mode=1: the block SHALL enter RESULT at the next edge, with mode taking priority over any valid_vote bits in the same cycle; that cycle's vote SHALL NOT be counted.
REQ-017 Tally update: a tally already at 2^COUNT_WIDTH-1 SHALL hold its value (saturate, no wrap), while ack still pulses.
REQ-018 LOCKOUT: the counter SHALL decrement by one each cycle, and the FSM SHALL return to IDLE on the edge where the counter reaches 0.
REQ-019 Lockout duration: the block SHALL spend exactly LOCKOUT_CYCLES cycles in LOCKOUT.
REQ-020 LOCKOUT: all valid_vote pulses and mode changes SHALL be ignored, with no tally change, no ack and no reject; mode is evaluated only once back in IDLE.
REQ-021 LOCKOUT: leds[3:0] SHALL show the one-hot accepted candidate, remaining leds bits SHALL be 0, and busy SHALL be 1.
REQ-022 IDLE: leds SHALL be 0 and busy SHALL be 0.
REQ-023 RESULT: leds SHALL equal the tally of the selected candidate, registered with 1-cycle latency after a tally or selector change.
REQ-024 RESULT: a one-hot valid_vote pulse SHALL update the selector to that candidate; multi-bit pulses SHALL be ignored; tallies SHALL never change; ack and reject SHALL stay 0.
REQ-025 RESULT with mode=0: the FSM SHALL return to IDLE at the next edge; the selector SHALL be retained.
REQ-026 ack and reject SHALL never be high in the same cycle, and neither SHALL ever stay high for more than one consecutive cycle.

Reset
REQ-027 When reset=1 at an edge, the block SHALL clear all tallies to 0, set the selector to candidate 1, clear the lockout counter, enter IDLE, and drive leds=0, ack=0, reject=0 and busy=0 on the following cycle.
REQ-028 Reset SHALL override all other inputs, including during LOCKOUT or RESULT, and the block SHALL abort any pending ack or reject.
REQ-029 The first cycle after reset deasserts SHALL be evaluated as IDLE.

Verification
REQ-030 Single vote: reset, mode=0, pulse valid_vote=4'b0010 for 1 cycle -> ack=1 the next cycle; tally2=1; busy=1 for 16 cycles; leds=8'h02 during LOCKOUT; then IDLE with leds=0.
REQ-031 Simultaneous: valid_vote=4'b0101 for 1 cycle in IDLE -> reject=1 for 1 cycle, ack=0, all tallies stay 0, busy=0.
REQ-032 Lockout: accepted vote for candidate 1, then pulses of 4'b0001 at lockout cycles 3 and 15 -> tally1=1 only; a pulse 1 cycle after busy falls -> tally1=2.
REQ-033 Saturation: COUNT_WIDTH=8, 257 accepted votes for candidate 4 -> tally4=255, and ack=1 on every one of the 257 votes.
REQ-034 Result: tallies {3,0,1,2}, mode=1, pulse 4'b0100 -> leds=1; pulse 4'b1000 -> leds=2; mode=0 -> IDLE with leds=0 and tallies unchanged.
REQ-035 Reset mid-lockout: reset asserted at lockout cycle 5 -> busy=0, leds=0 and all tallies 0 the next cycle; a new vote is accepted immediately after reset deasserts.
